// File: rtl/bit_comparator.sv
// 2-bit unsigned magnitude comparator with registered one-hot GT/EQ/LT flags,
// a one-cycle output-valid pulse and saturating per-result event counters.
module bit_comparator #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             A0,
  input  logic             A1,
  input  logic             B0,
  input  logic             B1,
  output logic             X,
  output logic             Y,
  output logic             Z,
  input  logic             in_valid,
  output logic             out_valid,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic             en);
    logic [CNT_W-1:0] res;
    if (en && (cnt != CNT_MAX)) begin
      res = cnt + CNT_W'(1'b1);
    end else begin
      res = cnt;
    end
    return res;
  endfunction

  logic             msb_eq_s;
  logic             gt_s;
  logic             eq_s;
  logic             lt_s;

  logic             x_q, x_d;
  logic             y_q, y_d;
  logic             z_q, z_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] gt_q, gt_d;
  logic [CNT_W-1:0] eq_q, eq_d;
  logic [CNT_W-1:0] lt_q, lt_d;

  // MSB decides unless equal, then the LSB decides.
  assign msb_eq_s = ~(A1 ^ B1);
  assign gt_s     = (A1 & ~B1) | (msb_eq_s & A0 & ~B0);
  assign eq_s     = msb_eq_s & ~(A0 ^ B0);
  assign lt_s     = (~A1 & B1) | (msb_eq_s & ~A0 & B0);

  // Next-state: load flags and bump one counter on each accepted request.
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    z_d   = z_q;
    vld_d = 1'b0;
    gt_d  = gt_q;
    eq_d  = eq_q;
    lt_d  = lt_q;
    if (in_valid) begin
      x_d   = gt_s;
      y_d   = eq_s;
      z_d   = lt_s;
      vld_d = 1'b1;
      gt_d  = sat_inc(gt_q, gt_s);
      eq_d  = sat_inc(eq_q, eq_s);
      lt_d  = sat_inc(lt_q, lt_s);
    end else begin
      vld_d = 1'b0;
    end
  end

  // State register; reset state encodes A=B=0, so Y starts high.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q   <= 1'b0;
      y_q   <= 1'b1;
      z_q   <= 1'b0;
      vld_q <= 1'b0;
      gt_q  <= {CNT_W{1'b0}};
      eq_q  <= {CNT_W{1'b0}};
      lt_q  <= {CNT_W{1'b0}};
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      z_q   <= z_d;
      vld_q <= vld_d;
      gt_q  <= gt_d;
      eq_q  <= eq_d;
      lt_q  <= lt_d;
    end
  end

  assign X         = x_q;
  assign Y         = y_q;
  assign Z         = z_q;
  assign out_valid = vld_q;
  assign gt_cnt    = gt_q;
  assign eq_cnt    = eq_q;
  assign lt_cnt    = lt_q;

endmodule

// File: tb/tb_bit_comparator.sv
// Directed self-checking bench for bit_comparator: default-width instance plus
// a CNT_W=2 instance sharing the same stimulus for the saturation case.
module tb_bit_comparator;

  logic       clk;
  logic       rst;
  logic       A0, A1, B0, B1;
  logic       in_valid;
  logic       X, Y, Z, out_valid;
  logic [7:0] gt_cnt, eq_cnt, lt_cnt;
  logic       X2, Y2, Z2, out_valid2;
  logic [1:0] gt_cnt2, eq_cnt2, lt_cnt2;

  int checks = 0;
  int errors = 0;

  bit_comparator #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .A0(A0), .A1(A1), .B0(B0), .B1(B1),
    .X(X), .Y(Y), .Z(Z), .in_valid(in_valid), .out_valid(out_valid),
    .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt)
  );

  bit_comparator #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .A0(A0), .A1(A1), .B0(B0), .B1(B1),
    .X(X2), .Y(Y2), .Z(Z2), .in_valid(in_valid), .out_valid(out_valid2),
    .gt_cnt(gt_cnt2), .eq_cnt(eq_cnt2), .lt_cnt(lt_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [1:0] a, input logic [1:0] b);
    rst      = r;
    in_valid = v;
    {A1, A0} = a;
    {B1, B0} = b;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag, input logic ex, input logic ey, input logic ez,
                           input logic ev);
    chk({tag, "_X"}, {31'd0, X}, {31'd0, ex});
    chk({tag, "_Y"}, {31'd0, Y}, {31'd0, ey});
    chk({tag, "_Z"}, {31'd0, Z}, {31'd0, ez});
    chk({tag, "_ov"}, {31'd0, out_valid}, {31'd0, ev});
  endtask

  task automatic chk_cnts(input string tag, input int eg, input int ee, input int el);
    chk({tag, "_gt"}, {24'd0, gt_cnt}, eg);
    chk({tag, "_eq"}, {24'd0, eq_cnt}, ee);
    chk({tag, "_lt"}, {24'd0, lt_cnt}, el);
  endtask

  initial begin
    logic [3:0] v4;
    logic [1:0] ra, rb;
    logic       rv;
    int mg, me, ml, acc;
    logic mx, my, mz;

    rst = 1'b1; in_valid = 1'b0; A0 = 1'b0; A1 = 1'b0; B0 = 1'b0; B1 = 1'b0;

    // Reset with a pending request: request is discarded
    step(1'b1, 1'b1, 2'd3, 2'd1);
    chk_flags("rst0", 1'b0, 1'b1, 1'b0, 1'b0);
    chk_cnts("rst0", 0, 0, 0);

    // Exhaustive 16 combinations, back-to-back
    for (int i = 0; i < 16; i++) begin
      v4 = i[3:0];
      step(1'b0, 1'b1, v4[3:2], v4[1:0]);
      chk_flags($sformatf("exh%0d", i), v4[3:2] > v4[1:0], v4[3:2] == v4[1:0],
                v4[3:2] < v4[1:0], 1'b1);
    end
    chk_cnts("exh_end", 6, 4, 6);

    // Hold behaviour
    step(1'b0, 1'b1, 2'd3, 2'd0);
    chk_flags("hold_load", 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 2'd0, 2'd3);
      chk_flags($sformatf("hold%0d", i), 1'b1, 1'b0, 1'b0, 1'b0);
      chk_cnts($sformatf("hold%0d", i), 7, 4, 6);
    end

    // Reset after activity
    step(1'b1, 1'b1, 2'd3, 2'd1);
    chk_flags("rst1", 1'b0, 1'b1, 1'b0, 1'b0);
    chk_cnts("rst1", 0, 0, 0);

    // First request after reset, no extra latency
    step(1'b0, 1'b1, 2'd1, 2'd2);
    chk_flags("first", 1'b0, 1'b0, 1'b1, 1'b1);
    chk_cnts("first", 0, 0, 1);

    // Saturation on the 2-bit instance
    step(1'b1, 1'b0, 2'd0, 2'd0);
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b1, 2'd1, 2'd1);
      chk($sformatf("sat_eq%0d", i), {30'd0, eq_cnt2}, (i > 3) ? 3 : i);
      chk($sformatf("sat_ov%0d", i), {31'd0, out_valid2}, 32'd1);
    end
    step(1'b0, 1'b0, 2'd1, 2'd1);
    chk("sat_hold_eq", {30'd0, eq_cnt2}, 32'd3);
    chk("sat_gt", {30'd0, gt_cnt2}, 32'd0);
    chk("sat_lt", {30'd0, lt_cnt2}, 32'd0);
    chk("sat_y", {31'd0, Y2}, 32'd1);

    // Random one-hot and counter-sum check
    step(1'b1, 1'b0, 2'd0, 2'd0);
    mg = 0; me = 0; ml = 0; acc = 0;
    mx = 1'b0; my = 1'b1; mz = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      ra = 2'($urandom_range(3, 0));
      rb = 2'($urandom_range(3, 0));
      rv = 1'($urandom_range(1, 0));
      step(1'b0, rv, ra, rb);
      if (rv) begin
        acc++;
        mx = (ra > rb); my = (ra == rb); mz = (ra < rb);
        if (mx && mg < 255) mg++;
        if (my && me < 255) me++;
        if (mz && ml < 255) ml++;
      end
      chk($sformatf("rnd_onehot%0d", i), 32'(X) + 32'(Y) + 32'(Z), 32'd1);
      chk_flags($sformatf("rnd%0d", i), mx, my, mz, rv);
      chk_cnts($sformatf("rnd%0d", i), mg, me, ml);
      if (acc <= 255) begin
        chk($sformatf("rnd_sum%0d", i), 32'(gt_cnt) + 32'(eq_cnt) + 32'(lt_cnt), acc);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
